// File: rtl/tff_mod_counter.sv
// Modulo-N up/down counter built from a chain of T flip-flops.
// Each bit toggles when its t_vec bit is set; tc/carry let stages be cascaded.

module tff_stage (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= q ^ t;
  end

endmodule

module tff_mod_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             carry,
  output logic             load_err
);

  localparam int unsigned       MAX_INT = MODULO - 1;
  localparam int unsigned       MOD_INT = MODULO;
  localparam logic [WIDTH-1:0]  MAX_VAL = MAX_INT[WIDTH-1:0];
  // One extra bit so MODULO == 2**WIDTH is representable in the range check.
  localparam logic [WIDTH:0]    MOD_EXT = MOD_INT[WIDTH:0];

  wire  [WIDTH-1:0] q_stage;
  logic [WIDTH-1:0] inc_t;
  logic [WIDTH-1:0] dec_t;
  logic             load_oob;
  logic             at_zero;
  logic             up_wrap;

  assign q        = q_stage;
  assign load_oob = ({1'b0, load_val} >= MOD_EXT);
  assign at_zero  = (q == '0);
  // Counting up from any out-of-range value also wraps, which recovers illegal states.
  assign up_wrap  = (q >= MAX_VAL);

  // Ripple toggle patterns: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic run_inc;
    logic run_dec;
    inc_t   = '0;
    dec_t   = '0;
    run_inc = 1'b1;
    run_dec = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      inc_t[i] = run_inc;
      dec_t[i] = run_dec;
      run_inc  = run_inc & q[i];
      run_dec  = run_dec & ~q[i];
    end
  end

  always_comb begin
    t_vec = '0;
    if (rst) begin
      t_vec = '0;
    end else if (load) begin
      t_vec = load_oob ? q : (q ^ load_val);
    end else if (en) begin
      if (up_dn) t_vec = up_wrap ? q : inc_t;
      else       t_vec = at_zero ? MAX_VAL : dec_t;
    end
  end

  assign tc = en & ~load & ~rst & ((up_dn & (q == MAX_VAL)) | (~up_dn & at_zero));

  always_ff @(posedge clk) begin
    if (rst) begin
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= tc;
      load_err <= load & load_oob;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    tff_stage u_stage (
      .clk (clk),
      .rst (rst),
      .t   (t_vec[i]),
      .q   (q_stage[i])
    );
  end

endmodule
